// File: rtl/misc_pipe_q_if.sv
// misc_pipe_q_if: bus bundle for the misc execution pipe.
//   exe_*      issue handshake and operands (issue -> pipe)
//   csr_*      CSR read port (pipe drives address, CSR file returns data)
//   cmt_*      commit handshake and payload (pipe -> ROB)
//   redirect_* early front-end redirect pulse
// Modports: slave = the pipe, master = whoever drives issue and consumes commit.
interface misc_pipe_q_if #(
   parameter int DATA_W  = 32,
   parameter int VA_W    = 32,
   parameter int ROB_W   = 6,
   parameter int PDEST_W = 6
);
   logic               exe_valid_i;
   logic               exe_ready_o;
   logic [3:0]         exe_op_i;
   logic [VA_W-1:0]    exe_pc_i;
   logic [VA_W-1:0]    exe_npc_i;
   logic [DATA_W-1:0]  exe_src0_i;
   logic [DATA_W-1:0]  exe_src1_i;
   logic [DATA_W-1:0]  exe_imm_i;
   logic [PDEST_W-1:0] exe_pdest_i;
   logic [ROB_W-1:0]   exe_rob_idx_i;

   logic [13:0]        csr_raddr_o;
   logic [DATA_W-1:0]  csr_rdata_i;

   logic               cmt_valid_o;
   logic               cmt_ready_i;
   logic [ROB_W-1:0]   cmt_rob_idx_o;
   logic [PDEST_W-1:0] cmt_pdest_o;
   logic               cmt_we_o;
   logic [DATA_W-1:0]  cmt_wdata_o;
   logic               cmt_csr_we_o;
   logic [13:0]        cmt_csr_waddr_o;
   logic [DATA_W-1:0]  cmt_csr_wdata_o;
   logic               cmt_br_taken_o;
   logic               cmt_br_redirect_o;
   logic [VA_W-1:0]    cmt_br_target_o;

   logic               redirect_valid_o;
   logic [VA_W-1:0]    redirect_target_o;
   logic [ROB_W-1:0]   redirect_rob_idx_o;

   modport slave (
      input  exe_valid_i, exe_op_i, exe_pc_i, exe_npc_i, exe_src0_i, exe_src1_i,
             exe_imm_i, exe_pdest_i, exe_rob_idx_i, csr_rdata_i, cmt_ready_i,
      output exe_ready_o, csr_raddr_o, cmt_valid_o, cmt_rob_idx_o, cmt_pdest_o,
             cmt_we_o, cmt_wdata_o, cmt_csr_we_o, cmt_csr_waddr_o, cmt_csr_wdata_o,
             cmt_br_taken_o, cmt_br_redirect_o, cmt_br_target_o,
             redirect_valid_o, redirect_target_o, redirect_rob_idx_o
   );

   modport master (
      output exe_valid_i, exe_op_i, exe_pc_i, exe_npc_i, exe_src0_i, exe_src1_i,
             exe_imm_i, exe_pdest_i, exe_rob_idx_i, csr_rdata_i, cmt_ready_i,
      input  exe_ready_o, csr_raddr_o, cmt_valid_o, cmt_rob_idx_o, cmt_pdest_o,
             cmt_we_o, cmt_wdata_o, cmt_csr_we_o, cmt_csr_waddr_o, cmt_csr_wdata_o,
             cmt_br_taken_o, cmt_br_redirect_o, cmt_br_target_o,
             redirect_valid_o, redirect_target_o, redirect_rob_idx_o
   );
endinterface

// File: rtl/misc_pipe_q.sv
// misc_pipe_q: branch/CSR execution pipe for the misc issue port.
// One operand-capture stage (S1) resolves branches and CSR read-modify-write,
// then pushes a result record into a DEPTH-entry circular commit queue whose
// head drives the cmt_* outputs. Mispredicted branches raise a registered
// one-cycle redirect pulse as they leave S1, ahead of commit.
// Ports: clk, rst (sync, active high), flush_i (kill all in-flight work),
//        bus (misc_pipe_q_if.slave: issue, CSR read, commit, redirect).
module misc_pipe_q #(
   parameter int DATA_W  = 32,
   parameter int VA_W    = 32,
   parameter int ROB_W   = 6,
   parameter int PDEST_W = 6,
   parameter int DEPTH   = 4
) (
   input logic            clk,
   input logic            rst,
   input logic            flush_i,
   misc_pipe_q_if.slave   bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [ROB_W-1:0]   rob_idx;
      logic [PDEST_W-1:0] pdest;
      logic               we;
      logic [DATA_W-1:0]  wdata;
      logic               csr_we;
      logic [13:0]        csr_waddr;
      logic [DATA_W-1:0]  csr_wdata;
      logic               br_taken;
      logic               br_redirect;
      logic [VA_W-1:0]    br_target;
   } ent_t;

   // S1 operand capture
   logic               s1_valid;
   logic [3:0]         s1_op;
   logic [VA_W-1:0]    s1_pc, s1_npc;
   logic [DATA_W-1:0]  s1_src0, s1_src1, s1_imm;
   logic [PDEST_W-1:0] s1_pdest;
   logic [ROB_W-1:0]   s1_rob_idx;

   // commit queue
   ent_t               q [DEPTH];
   logic [PTR_W-1:0]   head, tail;
   logic [CNT_W-1:0]   count;

   logic pop_raw, s1_fire, push, pop, accept;
   ent_t ent, head_ent;

   assign pop_raw = bus.cmt_valid_o & bus.cmt_ready_i;
   assign s1_fire = s1_valid & ((count < CNT_W'(DEPTH)) | pop_raw);
   assign bus.exe_ready_o = ~s1_valid | s1_fire;
   // Flush suppresses every state change except clearing.
   assign push   = s1_fire & ~flush_i;
   assign pop    = pop_raw & ~flush_i;
   assign accept = bus.exe_valid_i & bus.exe_ready_o & ~flush_i;

   assign bus.csr_raddr_o = s1_imm[13:0];

   // Branch resolution and writeback formation
   logic            eq, lt_s, lt_u, is_br, taken;
   logic [VA_W-1:0] base, target, pc4, next_pc;

   always_comb begin
      eq      = (s1_src0 == s1_src1);
      lt_s    = ($signed(s1_src0) < $signed(s1_src1));
      lt_u    = (s1_src0 < s1_src1);
      is_br   = (s1_op <= 4'd8);
      taken   = 1'b0;
      case (s1_op)
         4'd0: taken = eq;
         4'd1: taken = ~eq;
         4'd2: taken = lt_s;
         4'd3: taken = ~lt_s;
         4'd4: taken = lt_u;
         4'd5: taken = ~lt_u;
         4'd6, 4'd7, 4'd8: taken = 1'b1;
         default: taken = 1'b0;
      endcase
      base    = (s1_op == 4'd8) ? VA_W'(s1_src0) : s1_pc;
      target  = base + VA_W'(s1_imm);
      pc4     = s1_pc + VA_W'(4);
      next_pc = taken ? target : pc4;

      ent             = '0;
      ent.rob_idx     = s1_rob_idx;
      ent.pdest       = s1_pdest;
      ent.br_taken    = taken;
      ent.br_redirect = is_br & (next_pc != s1_npc);
      ent.br_target   = is_br ? next_pc : '0;
      case (s1_op)
         4'd7, 4'd8: begin
            ent.we    = 1'b1;
            ent.wdata = DATA_W'(pc4);
         end
         4'd9: begin
            ent.we    = 1'b1;
            ent.wdata = bus.csr_rdata_i;
         end
         4'd10: begin
            ent.we        = 1'b1;
            ent.wdata     = bus.csr_rdata_i;
            ent.csr_we    = 1'b1;
            ent.csr_waddr = s1_imm[13:0];
            ent.csr_wdata = s1_src0;
         end
         4'd11: begin
            // src1 is the bit mask: masked bits from src0, the rest keep old value
            ent.we        = 1'b1;
            ent.wdata     = bus.csr_rdata_i;
            ent.csr_we    = 1'b1;
            ent.csr_waddr = s1_imm[13:0];
            ent.csr_wdata = (s1_src0 & s1_src1) | (bus.csr_rdata_i & ~s1_src1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_op      <= '0;
         s1_pc      <= '0;
         s1_npc     <= '0;
         s1_src0    <= '0;
         s1_src1    <= '0;
         s1_imm     <= '0;
         s1_pdest   <= '0;
         s1_rob_idx <= '0;
      end else if (flush_i) begin
         s1_valid <= 1'b0;
      end else if (bus.exe_ready_o) begin
         s1_valid <= bus.exe_valid_i;
         if (accept) begin
            s1_op      <= bus.exe_op_i;
            s1_pc      <= bus.exe_pc_i;
            s1_npc     <= bus.exe_npc_i;
            s1_src0    <= bus.exe_src0_i;
            s1_src1    <= bus.exe_src1_i;
            s1_imm     <= bus.exe_imm_i;
            s1_pdest   <= bus.exe_pdest_i;
            s1_rob_idx <= bus.exe_rob_idx_i;
         end
      end
   end

   // Queue storage needs no reset: the head is masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (push) q[tail] <= ent;
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;
         if (pop)  head <= (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign bus.cmt_valid_o       = (count != '0);
   assign head_ent              = bus.cmt_valid_o ? q[head] : '0;
   assign bus.cmt_rob_idx_o     = head_ent.rob_idx;
   assign bus.cmt_pdest_o       = head_ent.pdest;
   assign bus.cmt_we_o          = head_ent.we;
   assign bus.cmt_wdata_o       = head_ent.wdata;
   assign bus.cmt_csr_we_o      = head_ent.csr_we;
   assign bus.cmt_csr_waddr_o   = head_ent.csr_waddr;
   assign bus.cmt_csr_wdata_o   = head_ent.csr_wdata;
   assign bus.cmt_br_taken_o    = head_ent.br_taken;
   assign bus.cmt_br_redirect_o = head_ent.br_redirect;
   assign bus.cmt_br_target_o   = head_ent.br_target;

   // Early redirect: one pulse per redirecting branch leaving S1.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.redirect_valid_o   <= 1'b0;
         bus.redirect_target_o  <= '0;
         bus.redirect_rob_idx_o <= '0;
      end else begin
         bus.redirect_valid_o <= push & ent.br_redirect;
         if (push & ent.br_redirect) begin
            bus.redirect_target_o  <= ent.br_target;
            bus.redirect_rob_idx_o <= ent.rob_idx;
         end
      end
   end
endmodule

// File: tb/tb_misc_pipe_q.sv
module tb_misc_pipe_q;
   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   misc_pipe_q_if #(.DATA_W(32), .VA_W(32), .ROB_W(6), .PDEST_W(6)) bus ();

   misc_pipe_q #(.DATA_W(32), .VA_W(32), .ROB_W(6), .PDEST_W(6), .DEPTH(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] npc,
                        input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] imm,
                        input logic [5:0] rob, input logic [5:0] pdest);
      bus.exe_valid_i   = 1'b1;
      bus.exe_op_i      = op;
      bus.exe_pc_i      = pc;
      bus.exe_npc_i     = npc;
      bus.exe_src0_i    = s0;
      bus.exe_src1_i    = s1;
      bus.exe_imm_i     = imm;
      bus.exe_rob_idx_i = rob;
      bus.exe_pdest_i   = pdest;
   endtask

   // Issue one op with an empty pipe; returns at the negedge where it heads the queue.
   task automatic run_one(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] npc,
                          input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] imm,
                          input logic [5:0] rob, input logic [5:0] pdest);
      @(negedge clk);
      issue(op, pc, npc, s0, s1, imm, rob, pdest);
      @(negedge clk);
      bus.exe_valid_i = 1'b0;
      chk("csr_raddr", bus.csr_raddr_o, imm[13:0]);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      bus.exe_valid_i = 1'b0;
      issue(4'hC, 0, 0, 0, 0, 0, 0, 0);
      bus.exe_valid_i = 1'b0;
      bus.csr_rdata_i = 32'h1234_5678;
      bus.cmt_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmt_valid", bus.cmt_valid_o, 0);
      chk("rst_redir_valid", bus.redirect_valid_o, 0);
      chk("rst_ready", bus.exe_ready_o, 1);
      chk("rst_raddr", bus.csr_raddr_o, 0);
      chk("rst_target", bus.cmt_br_target_o, 0);
      chk("rst_redir_target", bus.redirect_target_o, 0);
      rst = 1'b0;

      // BEQ taken, mispredicted
      run_one(4'h0, 32'h100, 32'h104, 5, 5, 32'h20, 6'd7, 6'd3);
      chk("beq_valid", bus.cmt_valid_o, 1);
      chk("beq_taken", bus.cmt_br_taken_o, 1);
      chk("beq_target", bus.cmt_br_target_o, 32'h120);
      chk("beq_redirect", bus.cmt_br_redirect_o, 1);
      chk("beq_we", bus.cmt_we_o, 0);
      chk("beq_rob", bus.cmt_rob_idx_o, 7);
      chk("beq_pdest", bus.cmt_pdest_o, 3);
      chk("beq_rv", bus.redirect_valid_o, 1);
      chk("beq_rtarget", bus.redirect_target_o, 32'h120);
      chk("beq_rrob", bus.redirect_rob_idx_o, 7);
      @(negedge clk);
      chk("beq_rv_pulse", bus.redirect_valid_o, 0);
      chk("beq_popped", bus.cmt_valid_o, 0);

      // BLT signed: -1 < 1 taken, predicted correctly
      run_one(4'h2, 32'h200, 32'h210, 32'hFFFF_FFFF, 1, 32'h10, 6'd8, 6'd1);
      chk("blt_taken", bus.cmt_br_taken_o, 1);
      chk("blt_target", bus.cmt_br_target_o, 32'h210);
      chk("blt_redirect", bus.cmt_br_redirect_o, 0);
      chk("blt_rv", bus.redirect_valid_o, 0);

      // BLTU: 0xFFFFFFFF < 1 false, falls through
      run_one(4'h4, 32'h200, 32'h204, 32'hFFFF_FFFF, 1, 32'h10, 6'd8, 6'd1);
      chk("bltu_taken", bus.cmt_br_taken_o, 0);
      chk("bltu_target", bus.cmt_br_target_o, 32'h204);
      chk("bltu_redirect", bus.cmt_br_redirect_o, 0);
      chk("bltu_rv", bus.redirect_valid_o, 0);

      // CSRXCHG
      run_one(4'hB, 32'h280, 32'h284, 32'hAAAA_AAAA, 32'h0000_FFFF, 32'h1005, 6'd9, 6'd4);
      chk("xchg_csr_we", bus.cmt_csr_we_o, 1);
      chk("xchg_csr_wdata", bus.cmt_csr_wdata_o, 32'h1234_AAAA);
      chk("xchg_csr_waddr", bus.cmt_csr_waddr_o, 14'h1005);
      chk("xchg_we", bus.cmt_we_o, 1);
      chk("xchg_wdata", bus.cmt_wdata_o, 32'h1234_5678);
      chk("xchg_taken", bus.cmt_br_taken_o, 0);
      chk("xchg_rv", bus.redirect_valid_o, 0);

      // JIRL wrapping target
      run_one(4'h8, 32'h300, 32'h304, 32'hFFFF_FFFC, 0, 8, 6'd11, 6'd5);
      chk("jirl_target", bus.cmt_br_target_o, 32'h4);
      chk("jirl_taken", bus.cmt_br_taken_o, 1);
      chk("jirl_wdata", bus.cmt_wdata_o, 32'h304);
      chk("jirl_we", bus.cmt_we_o, 1);
      chk("jirl_rv", bus.redirect_valid_o, 1);
      chk("jirl_rtarget", bus.redirect_target_o, 32'h4);

      // Back-to-back mispredicted B ops -> consecutive redirect pulses
      @(negedge clk);
      issue(4'h6, 32'h400, 32'h404, 0, 0, 32'h40, 6'd1, 6'd0);
      @(negedge clk);
      issue(4'h6, 32'h500, 32'h504, 0, 0, 32'h80, 6'd2, 6'd0);
      @(negedge clk);
      bus.exe_valid_i = 1'b0;
      chk("b2b_rv0", bus.redirect_valid_o, 1);
      chk("b2b_rrob0", bus.redirect_rob_idx_o, 1);
      chk("b2b_rtarget0", bus.redirect_target_o, 32'h440);
      @(negedge clk);
      chk("b2b_rv1", bus.redirect_valid_o, 1);
      chk("b2b_rrob1", bus.redirect_rob_idx_o, 2);
      chk("b2b_rtarget1", bus.redirect_target_o, 32'h580);
      repeat (2) @(negedge clk);
      chk("b2b_drained", bus.cmt_valid_o, 0);

      // Full queue (DEPTH=3) with commit stalled, then release
      bus.cmt_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         issue(4'hC, 32'h600, 32'h604, 0, 0, 0, 6'(10 + k), 6'(k));
      end
      @(negedge clk);
      issue(4'hC, 32'h600, 32'h604, 0, 0, 0, 6'd14, 6'd4);
      chk("full_ready", bus.exe_ready_o, 0);
      chk("full_valid", bus.cmt_valid_o, 1);
      chk("full_head", bus.cmt_rob_idx_o, 10);
      @(negedge clk);
      chk("full_ready_hold", bus.exe_ready_o, 0);
      chk("full_head_hold", bus.cmt_rob_idx_o, 10);
      bus.cmt_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("drain_valid", bus.cmt_valid_o, 1);
         chk("drain_rob", bus.cmt_rob_idx_o, 64'(10 + i));
         chk("drain_we", bus.cmt_we_o, 0);
         @(negedge clk);
         bus.exe_valid_i = 1'b0;
      end
      chk("drain_empty", bus.cmt_valid_o, 0);

      // Flush with 2 queued entries and a mispredicted branch in S1
      bus.cmt_ready_i = 1'b0;
      @(negedge clk);
      issue(4'hC, 32'h700, 32'h704, 0, 0, 0, 6'd20, 6'd0);
      @(negedge clk);
      issue(4'hC, 32'h700, 32'h704, 0, 0, 0, 6'd21, 6'd0);
      @(negedge clk);
      issue(4'h6, 32'h800, 32'h804, 0, 0, 32'h100, 6'd22, 6'd0);
      @(negedge clk);
      bus.exe_valid_i = 1'b0;
      chk("preflush_valid", bus.cmt_valid_o, 1);
      chk("preflush_head", bus.cmt_rob_idx_o, 20);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_cmt_valid", bus.cmt_valid_o, 0);
      chk("flush_rv", bus.redirect_valid_o, 0);
      chk("flush_ready", bus.exe_ready_o, 1);
      @(negedge clk);
      chk("flush_rv_after", bus.redirect_valid_o, 0);
      chk("flush_cmt_after", bus.cmt_valid_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/misc_pipe_q.md
# misc_pipe_q

Parametrised branch/CSR execution pipe for the misc issue port: one operand-capture stage, in-stage branch resolution and CSR read-modify-write, and a DEPTH-entry commit queue toward the ROB. Unlike a single output register, the queue decouples commit stalls from issue. An early, one-cycle redirect pulse is raised as soon as a mispredicted branch resolves, without waiting for it to reach commit.

## Interface
- DATA_W, 32, operand/result width
- VA_W, 32, PC/target width
- ROB_W, 6, ROB index width
- PDEST_W, 6, physical destination width
- DEPTH, 4, commit queue entries (>=1, any integer)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  kill all in-flight work
- exe_valid_i / exe_ready_o  in/out  1  issue handshake
- exe_op_i  in  4  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 B, 7 BL, 8 JIRL, 9 CSRRD, A CSRWR, B CSRXCHG, C-F no-op
- exe_pc_i, exe_npc_i  in  VA_W  PC, predicted next PC
- exe_src0_i, exe_src1_i, exe_imm_i  in  DATA_W  operands; imm pre-extended
- exe_pdest_i  in  PDEST_W;  exe_rob_idx_i  in  ROB_W
- csr_raddr_o  out  14  = s1 imm[13:0]
- csr_rdata_i  in  DATA_W  combinational read data, same cycle
- cmt_valid_o / cmt_ready_i  out/in  1  commit handshake (queue head)
- cmt_rob_idx_o, cmt_pdest_o, cmt_we_o, cmt_wdata_o  out  ROB_W/PDEST_W/1/DATA_W
- cmt_csr_we_o, cmt_csr_waddr_o(14), cmt_csr_wdata_o(DATA_W)  out
- cmt_br_taken_o, cmt_br_redirect_o  out  1;  cmt_br_target_o  out  VA_W
- redirect_valid_o  out  1;  redirect_target_o  out  VA_W;  redirect_rob_idx_o  out  ROB_W

## Operation
- S1: single register; loads when exe_valid_i & exe_ready_o.
- exe_ready_o = ~s1_valid | s1_fire; s1_fire = s1_valid & (count<DEPTH | pop). pop = cmt_valid_o & cmt_ready_i.
- Branch compare: BEQ/BNE equality; BLT/BGE signed; BLTU/BGEU unsigned; src0 vs src1. B/BL/JIRL always taken.
- Target: JIRL src0+imm; others pc+imm; VA_W bits, wrap modulo 2^VA_W.
- Actual next = taken ? target : pc+4. redirect = branch op & (actual next != npc). cmt_br_target_o = actual next.
- Writeback: BL, JIRL write pc+4 (zero-extended); CSRRD/CSRWR/CSRXCHG write csr_rdata_i (old value); else cmt_we_o=0, wdata=0.
- CSR write: CSRWR wdata=src0; CSRXCHG wdata=(src0&src1)|(csr_rdata_i&~src1); csr_we only for these two; waddr=imm[13:0].
- Ops C-F: complete with all side-effect flags 0.
- Queue: circular, head/tail pointers wrap at DEPTH (non power of two allowed), count 0..DEPTH; simultaneous push and pop on full queue permitted, count unchanged.
- Early redirect: registered; pulses one cycle after s1_fire of a redirecting branch, carrying target/rob_idx. Back-to-back redirecting branches give consecutive pulses.
- flush_i: highest priority; next cycle S1 empty, queue empty, redirect_valid_o 0; no push, pop, or S1 load that cycle; exe_ready_o still follows formula but acceptance is discarded.

## Timing
- Reset (rst=1 at edge): all cmt_* outputs, redirect_* outputs, and csr_raddr_o read 0; count=0; exe_ready_o=1.
- Issue at edge t -> in S1 during t+1 -> queue head (if empty, cmt_valid_o) during t+2. Latency 2.
- redirect_valid_o high during t+2 for a branch issued at t that fires immediately.
- Throughput 1/cycle while cmt_ready_i=1.
- cmt_* outputs are a pure function of queue head; stable while cmt_valid_o & ~cmt_ready_i.
- Queue full & no pop: S1 holds; exe_ready_o=0 if S1 valid.

## Test plan
- Reset then BEQ src0=src1=5, pc=0x100, imm=0x20, npc=0x104 -> cycle+2: cmt_br_taken=1, target=0x120, redirect=1; redirect_valid_o pulses same cycle, rob_idx matches.
- BLT src0=0xFFFFFFFF, src1=1 -> taken. BLTU with the same operands -> not taken; npc=pc+4 gives redirect=0.
- CSRXCHG src0=0xAAAA_AAAA, src1=0x0000_FFFF, csr_rdata=0x1234_5678 -> csr_wdata=0x1234_AAAA, wdata=0x1234_5678, csr_we=1.
- DEPTH=3, cmt_ready_i=0, issue 5 ops -> 3 queued + 1 in S1, exe_ready_o=0. Release ready -> 5 commits in issue order, 1/cycle.
- flush_i while queue holds 2 entries and S1 holds a mispredicted branch -> next cycle cmt_valid_o=0, no redirect pulse.
- JIRL src0=0xFFFF_FFFC, imm=8 -> target wraps to 0x4; wdata=pc+4.
